conv_window_mac: RTL
====================

// Module: conv_window_mac
//
// PURPOSE
// Streaming 2-D convolution stage, directly downstream of the line-delay shift registers.
// - Input: raster-order pixel stream, one pixel per accepted cycle.
// - Buffers filterWidth-1 image lines and forms a filterWidth x filterWidth window.
// - Multiplies the window by a loaded signed kernel and emits one sum per fully valid window position.
// - Output feeds the activation/pooling stage.
//
// PARAMETERS
// bitwidth     8   unsigned pixel width
// weightWidth  8   signed kernel coefficient width
// imageWidth   11  pixels per line
// imageHeight  11  lines per frame
// filterWidth  3   kernel edge length; filterSize = filterWidth*filterWidth (localparam)
// accWidth     localparam = bitwidth+weightWidth+1+$clog2(filterSize)
//
// PORTS
// clock        in   1                  sole clock, rising edge
// reset        in   1                  synchronous, active-high
// in_valid     in   1                  data_in accepted this cycle
// data_in      in   bitwidth           pixel, unsigned
// weight_we    in   1                  kernel write strobe
// weight_addr  in   $clog2(filterSize) r*filterWidth+c; r=0 is top row, c=0 is left column
// weight_data  in   weightWidth        signed coefficient
// weight_err   out  1                  1-cycle pulse: write rejected
// out_valid    out  1                  out_data valid, 1-cycle per result
// out_data     out  accWidth           signed window sum, full precision
// frame_done   out  1                  1-cycle pulse with the last result of a frame
//
// BEHAVIOUR
// - Reset values: out_valid=0, out_data=0, frame_done=0, weight_err=0, state=IDLE, col=row=0.
//   - Valid-tag pipeline is cleared; results in flight are dropped.
//   - Kernel registers are cleared to 0.
//   - Line/window storage is not cleared; it is gated by the counters.
// - FSM:
//   - IDLE -> STREAM on the first in_valid.
//   - STREAM -> IDLE the cycle after pixel (imageHeight-1, imageWidth-1) is accepted.
//   - Counters: col wraps at imageWidth-1 and increments row; row wraps at imageHeight-1 to 0.
// - Flow control:
//   - No backpressure: every in_valid pixel is consumed.
//   - Without in_valid, window, line buffers and counters hold.
// - Window position: accepted pixel at (row, col) is the bottom-right of the window.
//   - Window is valid iff row>=filterWidth-1 && col>=filterWidth-1.
//   - Windows that straddle a line wrap never produce output.
// - Pipeline: S1 registers the filterSize signed products; S2 registers the adder-tree sum to out_data.
//   - out_valid asserts exactly 2 cycles after the accepting edge of a window-valid pixel, independent of later in_valid gaps.
//   - Per frame: (imageWidth-filterWidth+1)*(imageHeight-filterWidth+1) results, raster order.
// - Arithmetic: pixel zero-extended to bitwidth+1, multiplied signed; sum sign-extended to accWidth.
//   - No rounding, no saturation.
// - Kernel load:
//   - weight_we is honoured only in IDLE with no result in flight; the new value is used by the next frame.
//   - Otherwise the write is ignored and weight_err pulses the next cycle.
//   - Same-address writes in consecutive cycles: last write wins.
// - frame_done coincides with out_valid of the final window of the frame.
// - reset mid-frame: the partial frame is abandoned; the next in_valid restarts at (0,0).
//
// STRUCTURE
// - Shared package conv_pkg:
//   - pixel_t, weight_t, acc_t typedefs.
//   - Function acc_width(bitwidth, weightWidth, filterSize).
//   - Enum conv_state_t {IDLE, STREAM}.
// - Sub-module conv_line_delay (bitwidth, depth=imageWidth, ports clock/reset/enable/data_in/data_out):
//   - filterWidth-1 instances, chained, all enabled by in_valid.
//   - Window shift registers, counters, FSM and MAC pipeline live in this module.
//
// TESTING (imageWidth=5, imageHeight=5, filterWidth=3, bitwidth=8, weightWidth=8)
// 1 All weights 1, all pixels 1, continuous in_valid
//   -> 9 results of 9.
//   -> First out_valid exactly 2 cycles after pixel index 12 is accepted.
//   -> frame_done with the 9th result.
// 2 Kernel with only addr 4 = 1, pixel value = raster index 0..24
//   -> outputs 6,7,8,11,12,13,16,17,18 in order.
// 3 All weights -1, all pixels 255 -> every out_data = -2295 (signed, accWidth).
// 4 Scenario 2 with random 0-3 cycle in_valid gaps -> identical value sequence, each 2 cycles after its pixel.
// 5 Reset asserted for 1 cycle after 13 pixels, then a full scenario-1 frame
//   -> exactly 9 results; nothing from the aborted frame.
// 6 weight_we (addr 0, data 5) during STREAM
//   -> weight_err pulse next cycle.
//   -> Current and next frame outputs unchanged.
//   -> The same write in IDLE is accepted.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming convolution stage.
package conv_pkg;

  localparam int unsigned PIX_W       = 8;
  localparam int unsigned WGT_W       = 8;
  localparam int unsigned FILTER_SIZE = 9;

  // Full-precision accumulator width: signed product of a zero-extended
  // pixel and a signed weight, plus growth for summing filter_size terms.
  function automatic int unsigned acc_width(input int unsigned bw,
                                            input int unsigned ww,
                                            input int unsigned fs);
    return bw + ww + 1 + $clog2(fs);
  endfunction

  localparam int unsigned ACC_W = acc_width(PIX_W, WGT_W, FILTER_SIZE);

  typedef logic        [PIX_W-1:0] pixel_t;
  typedef logic signed [WGT_W-1:0] weight_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } conv_state_t;

endpackage

// File: rtl/conv_line_delay.sv
// One image line of delay: a depth-stage shift register advanced only when
// a pixel is accepted, so it always holds the previous `depth` pixels.
module conv_line_delay #(
  parameter int bitwidth = 8,
  parameter int depth    = 11
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [bitwidth-1:0] data_in,
  output logic [bitwidth-1:0] data_out
);

  logic [bitwidth-1:0] taps_q [depth];

  // Shift one pixel per accepted cycle; hold while reset is asserted.
  // NOTE: the storage has no reset value on purpose -- its contents are
  // never used until the row/column counters have refilled it.
  always_ff @(posedge clock) begin
    if (enable && !reset) begin
      taps_q[0] <= data_in;
      for (int i = 1; i < depth; i++) taps_q[i] <= taps_q[i-1];
    end
  end

  assign data_out = taps_q[depth-1];

endmodule

// File: rtl/conv_window_mac.sv
// Streaming 2-D convolution: line delays build a filterWidth x filterWidth
// window, S1 registers the products, S2 registers the adder-tree sum.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int bitwidth    = 8,
  parameter int weightWidth = 8,
  parameter int imageWidth  = 11,
  parameter int imageHeight = 11,
  parameter int filterWidth = 3,
  localparam int filterSize = filterWidth * filterWidth,
  localparam int accWidth   = acc_width(bitwidth, weightWidth, filterSize),
  localparam int addrWidth  = $clog2(filterSize)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [bitwidth-1:0]        data_in,
  input  logic                       weight_we,
  input  logic [addrWidth-1:0]       weight_addr,
  input  logic [weightWidth-1:0]     weight_data,
  output logic                       weight_err,
  output logic                       out_valid,
  output logic [accWidth-1:0]        out_data,
  output logic                       frame_done
);

  localparam int colWidth  = (imageWidth  > 1) ? $clog2(imageWidth)  : 1;
  localparam int rowWidth  = (imageHeight > 1) ? $clog2(imageHeight) : 1;
  localparam int prodWidth = bitwidth + 1 + weightWidth;

  conv_state_t          state_q, state_d;
  logic [colWidth-1:0]  col_q, col_d;
  logic [rowWidth-1:0]  row_q, row_d;
  logic                 col_last, row_last, frame_last, win_ok, addr_ok, weight_ok;
  logic                 v0_q, v1_q, last0_q, last1_q;
  logic                 out_valid_q, frame_done_q, weight_err_q;
  logic [accWidth-1:0]  out_data_q;
  logic signed [accWidth-1:0]    acc_sum;
  logic signed [weightWidth-1:0] weight_q [filterSize];
  logic signed [prodWidth-1:0]   prod_q   [filterSize];
  logic [bitwidth-1:0]           win_q    [filterWidth][filterWidth];
  // col_tap[filterWidth-1] is the current line, col_tap[0] the oldest line.
  logic [bitwidth-1:0]           col_tap  [filterWidth];

  assign col_tap[filterWidth-1] = data_in;

  for (genvar k = 0; k < filterWidth - 1; k++) begin : gen_delay
    conv_line_delay #(.bitwidth(bitwidth), .depth(imageWidth)) u_delay (
      .clock   (clock),
      .reset   (reset),
      .enable  (in_valid),
      .data_in (col_tap[filterWidth-1-k]),
      .data_out(col_tap[filterWidth-2-k])
    );
  end

  assign col_last   = (col_q == colWidth'(imageWidth - 1));
  assign row_last   = (row_q == rowWidth'(imageHeight - 1));
  assign frame_last = col_last && row_last;
  assign win_ok     = in_valid && (row_q >= rowWidth'(filterWidth - 1))
                               && (col_q >= colWidth'(filterWidth - 1));
  assign addr_ok    = ({1'b0, weight_addr} < (addrWidth + 1)'(filterSize));

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: a frame starts on the first pixel, ends on the last one.
  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && !frame_last) state_d = STREAM;
      STREAM:  if (in_valid &&  frame_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: kernel writes only land between frames with nothing in flight.
  always_comb begin
    weight_ok = 1'b0;
    if (state_q == IDLE && !v0_q && !v1_q && weight_we && addr_ok) weight_ok = 1'b1;
  end

  // Raster position of the next pixel to be accepted.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Counter registers.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Window shift: newest column enters on the right, one column per pixel.
  always_ff @(posedge clock) begin
    if (in_valid) begin
      for (int r = 0; r < filterWidth; r++) begin
        for (int c = 0; c < filterWidth - 1; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][filterWidth-1] <= col_tap[r];
      end
    end
  end

  // Kernel registers and the reject pulse for writes that arrive too late.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < filterSize; i++) weight_q[i] <= '0;
      weight_err_q <= 1'b0;
    end else begin
      if (weight_ok) weight_q[weight_addr] <= weight_data;
      weight_err_q <= weight_we && !weight_ok;
    end
  end

  // S1: products of the zero-extended pixels and signed weights.
  always_ff @(posedge clock) begin
    for (int r = 0; r < filterWidth; r++)
      for (int c = 0; c < filterWidth; c++)
        prod_q[r*filterWidth+c] <= prodWidth'($signed({1'b0, win_q[r][c]}))
                                 * prodWidth'(weight_q[r*filterWidth+c]);
  end

  // Adder tree over the registered products, sign-extended to full width.
  // NOTE: blocking assignments are correct here -- this is combinational.
  always_comb begin
    acc_sum = '0;
    for (int i = 0; i < filterSize; i++) acc_sum = acc_sum + accWidth'(prod_q[i]);
  end

  // Valid/last tags follow the data through both stages; S2 captures the sum.
  always_ff @(posedge clock) begin
    if (reset) begin
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
      last0_q      <= 1'b0;
      last1_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      v0_q         <= win_ok;
      last0_q      <= win_ok && frame_last;
      v1_q         <= v0_q;
      last1_q      <= last0_q;
      out_valid_q  <= v1_q;
      frame_done_q <= v1_q && last1_q;
      if (v1_q) out_data_q <= acc_sum;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;
  assign weight_err = weight_err_q;

endmodule
